// File: rtl/uart_transmitter.sv
// UART transmitter: start, DATA_SIZE data bits LSB first, even parity, stop.
// Each bit is held for OVERSAMPLE clocks. Break frames are sent on request.
module uart_transmitter #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 break_req,
  output logic                 serial_data_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  // A break frame counts DATA_SIZE+3 bit periods, so bit_count must reach DATA_SIZE+2.
  localparam int unsigned BW = $clog2(DATA_SIZE + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  logic [SW-1:0]          r_sample;
  logic [BW-1:0]          r_bit;
  logic [DATA_SIZE-1:0]   r_shift;
  logic                   r_parity;
  logic                   r_line;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;

  state_t                 w_state_nxt;
  logic [SW-1:0]          w_sample_nxt;
  logic [BW-1:0]          w_bit_nxt;
  logic [DATA_SIZE-1:0]   w_shift_nxt;
  logic                   w_parity_nxt;
  logic                   w_line_nxt;
  logic                   w_done_nxt;
  logic                   w_bit_end;

  assign w_bit_end = (r_sample == SW'(OVERSAMPLE - 1));

  // State, counters, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_line   <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sample <= w_sample_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_line   <= w_line_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed from the next state
  // so the registered line changes in the same cycle as the state.
  always_comb begin
    w_state_nxt  = r_state;
    w_sample_nxt = r_sample + SW'(1);
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_line_nxt   = 1'b1;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sample_nxt = '0;
        w_bit_nxt    = '0;
        if (break_req) begin
          w_state_nxt = S_BREAK;
        end else if (tx_valid) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = data_in;
          w_parity_nxt = ^data_in;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt  = S_DATA;
          w_sample_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_sample_nxt = '0;
          w_shift_nxt  = r_shift >> 1;
          if (r_bit == BW'(DATA_SIZE - 1)) begin
            w_state_nxt = S_PARITY;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt  = S_STOP;
          w_sample_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt  = S_IDLE;
          w_sample_nxt = '0;
        end
      end
      S_BREAK: begin
        if (w_bit_end) begin
          w_sample_nxt = '0;
          if (r_bit == BW'(DATA_SIZE + 2)) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_sample_nxt = '0;
        w_bit_nxt    = '0;
      end
    endcase

    case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = w_shift_nxt[0];
      S_PARITY: w_line_nxt = w_parity_nxt;
      S_BREAK:  w_line_nxt = 1'b0;
      default:  w_line_nxt = 1'b1;
    endcase

    if (w_sample_nxt == SW'(OVERSAMPLE - 1)) begin
      if (w_state_nxt == S_STOP) begin
        w_done_nxt = 1'b1;
      end else if (w_state_nxt == S_BREAK && w_bit_nxt == BW'(DATA_SIZE + 2)) begin
        w_done_nxt = 1'b1;
      end
    end
  end

  assign serial_data_out = r_line;
  assign tx_ready        = r_ready;
  assign tx_busy         = r_busy;
  assign tx_done         = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Cycle-exact scoreboard bench for uart_transmitter: every cycle the line,
// tx_done, tx_busy and tx_ready are compared against a queued expectation.
module tb_uart_transmitter;

  localparam int unsigned D     = 8;
  localparam int unsigned OS    = 16;
  localparam int unsigned FRAME = (D + 3) * OS;

  logic         clk;
  logic         reset_n;
  logic [D-1:0] data_in;
  logic         tx_valid;
  logic         tx_ready;
  logic         break_req;
  logic         serial_data_out;
  logic         tx_busy;
  logic         tx_done;

  // Expected {line, done, busy, ready} per cycle; empty queue means idle.
  logic [3:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       chk_en = 1'b0;

  uart_transmitter #(.DATA_SIZE(D), .OVERSAMPLE(OS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .data_in         (data_in),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .break_req       (break_req),
    .serial_data_out (serial_data_out),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] exp_v;
      logic [3:0] obs_v;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b1001;
      obs_v = {serial_data_out, tx_done, tx_busy, tx_ready};
      n_cmp++;
      assert (obs_v === exp_v) else begin
        n_err++;
        $error("FAIL cycle t=%0t {line,done,busy,ready} observed=%b expected=%b",
               $time, obs_v, exp_v);
      end
    end
  end

  task automatic push_frame(input logic [D-1:0] d, input logic brk);
    int   b;
    logic ln;
    for (int i = 0; i < int'(FRAME); i++) begin
      b = i / int'(OS);
      if (brk)                ln = 1'b0;
      else if (b == 0)        ln = 1'b0;
      else if (b <= int'(D))  ln = d[b-1];
      else if (b == int'(D)+1) ln = ^d;
      else                    ln = 1'b1;
      exp_q.push_back({ln, (i == int'(FRAME) - 1), 1'b1, 1'b0});
    end
    exp_q.push_back(4'b1001);
  endtask

  // Offer a word (and optionally a break); the accept edge is the first
  // posedge at which the model says the transmitter is idle.
  task automatic send(input logic [D-1:0] d, input logic brk);
    bit ok;
    @(negedge clk);
    data_in   = d;
    tx_valid  = 1'b1;
    break_req = brk;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        push_frame(d, brk);
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic release_inputs();
    @(negedge clk);
    tx_valid  = 1'b0;
    break_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $error("FAIL idle_timeout observed=pending=%0d expected=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_valid  = 1'b0;
    break_req = 1'b0;
    data_in   = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic frame with alternating data pattern
    send(8'hA5, 1'b0);
    release_inputs();
    wait_idle();

    // Odd number of ones -> parity bit 1
    send(8'h07, 1'b0);
    release_inputs();
    wait_idle();

    // tx_valid held high across two frames: one idle cycle, 177-cycle spacing
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b0);
    release_inputs();
    wait_idle();

    // Break and data requested together: break wins, data dropped
    send(8'hFF, 1'b1);
    release_inputs();
    wait_idle();

    // Break request during a frame is ignored and not queued
    send(8'h81, 1'b0);
    @(negedge clk);
    tx_valid  = 1'b0;
    break_req = 1'b1;
    repeat (50) @(negedge clk);
    break_req = 1'b0;
    wait_idle();

    // Reset pulse during data bit 3 aborts the frame without tx_done
    send(8'h96, 1'b0);
    release_inputs();
    repeat (68) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    send(8'h69, 1'b0);
    release_inputs();
    wait_idle();

    // data_in toggled mid-frame must not affect the transmitted word
    send(8'h5A, 1'b0);
    release_inputs();
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      data_in = D'($urandom);
    end
    wait_idle();

    // Boundary words
    send(8'h00, 1'b0);
    release_inputs();
    wait_idle();
    send(8'hFF, 1'b0);
    release_inputs();
    wait_idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
